fpu_share_arbiter: RTL and testbench
====================================

Name: fpu_share_arbiter

Overview:
- Shares one floating-point multiplier core (MULT) and one floating-point adder core (ADD) among NREQ requesters, e.g. the complementary filter, the gyro calibration and the angle-to-direction logic.
- Requesters no longer use fixed 100-cycle wait counters. Each requester issues one operation and receives a done pulse plus a registered result exactly when the core output is valid.
- Sits between the sensor-math blocks and the MULT/ADD IP cores. It drives the core operand inputs and tracks in-flight operations with tag pipelines.

Parameters:
- NREQ, 3, number of requesters (2..8).
- MUL_LAT, 5, MULT clocks from operand registers loaded to result valid.
- ADD_LAT, 7, ADD clocks from operand registers loaded to result valid.
- IDW, $clog2(NREQ), requester-id width (derived, not overridable).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level; held until ack.
- op  in  NREQ  per-requester opcode: 0 = multiply, 1 = add.
- a_flat  in  32*NREQ  operand A, IEEE-754 single; requester i uses bits [32i+31:32i].
- b_flat  in  32*NREQ  operand B, same packing as a_flat.
- ack  out  NREQ  one-cycle pulse: request accepted.
- done  out  NREQ  one-cycle pulse: result_flat slot is valid.
- result_flat  out  32*NREQ  per-requester result register.
- pending  out  NREQ  requester has an operation in flight.
- mul_a, mul_b  out  32  MULT operands (registered).
- mul_res  in  32  MULT result.
- add_a, add_b  out  32  ADD operands (registered).
- add_res  in  32  ADD result.
- busy  out  1  OR of pending.

Behaviour:
- Reset (rst=0, async):
  - ack, done, pending, result_flat, mul_a/b and add_a/b all 0.
  - Round-robin pointer = 0; all tag pipelines invalid.
- Eligibility: requester i is eligible when req[i]=1 and pending[i]=0.
- Grant, cycle C:
  - At most ONE grant per cycle.
  - Winner is the first eligible index at or after the pointer, searching upward modulo NREQ. This holds regardless of opcode.
- Issue, edge ending C:
  - Winner operands go to mul_a/mul_b (op=0) or add_a/add_b (op=1). The other core's operand registers hold their values.
  - pending[w] is set.
  - Tag {valid=1, id=w} enters stage 0 of that core's tag pipe.
  - Pointer becomes (w+1) mod NREQ.
  - ack[w]=1 during cycle C+1.
- Idle cycle (no eligible requester): pointer and operand registers are unchanged, and a valid=0 tag enters both pipes.
- Completion:
  - The MULT tag exits after MUL_LAT stages. At that edge, mul_res is captured into result slot id, pending[id] clears, and done[id]=1 during the next cycle.
  - Multiply latency is therefore ack in C+1, done in C+1+MUL_LAT. For add, use ADD_LAT in place of MUL_LAT.
- Simultaneous completions: MULT and ADD exits always target different ids, because only one op per requester can be in flight. Both slots update and both done bits pulse in the same cycle.
- Completion and new grant for the same id in one cycle: the id is not eligible in that cycle (pending still 1). It can be granted at the earliest in the cycle where done is high.
- Requester contract: req may stay high through ack. After the done cycle, a still-high req is treated as a new request.
- Operand sampling: operands are sampled only on the grant edge. Changes afterwards have no effect.
- result_flat: each slot holds its value until that requester's next completion.
- Mid-operation reset: clears everything immediately. Core outputs that arrive after reset are ignored, because the tags are invalid.
- No arithmetic is done in this block. Operands and results pass through unmodified.

Decomposition:
- Package fpu_pkg:
  - OP_MUL=1'b0, OP_ADD=1'b1.
  - FP_W=32.
  - Filter constants K_0P1=32'h3DCCC800, K_GYDT=32'h3D385000, K_0P9=32'h3F666600.
- One sub-module: fpu_tag_pipe.
  - Parameterised depth LAT and width IDW+1.
  - Shift register with async active-low reset.
  - Instantiated once for MULT (LAT=MUL_LAT) and once for ADD (LAT=ADD_LAT).
- The bench models MULT/ADD as LAT-stage behavioural pipelines.

Test Plan:
- Single multiply: req0 with op=0, A=40000000 (2.0), B=40400000 (3.0) in cycle 1 -> ack[0] in cycle 2, done[0] in cycle 2+MUL_LAT=7, result slot0=40C00000, pending[0] clear after cycle 7.
- Single add: req1 with op=1, A=3F800000, B=40000000 -> done[1] exactly ADD_LAT=7 cycles after ack[1], slot1=40400000.
- Round-robin: req0..2 all high from reset -> ack order 0, 1, 2 on consecutive cycles. Raising req0 again after its done -> next grant goes to 0 only once no lower-pointer eligible requester remains.
- Concurrent completion: req0 op=0 granted 2 cycles after req1 op=1 (MUL_LAT=5, ADD_LAT=7) -> done[0] and done[1] high in the same cycle, both slots correct.
- Held req: req2 held high for 20 cycles with op=0 -> exactly one ack per completion, never a second ack while pending[2]=1. The next ack arrives at the earliest in the cycle done[2] is high, and again at the earliest in each subsequent done[2] cycle.
- Reset mid-flight: assert rst 2 cycles after ack[0] -> all outputs 0 immediately, no done pulse after release, next req0 serviced normally.

Source files
------------

// File: rtl/fpu_share_arbiter_pkg.sv
// Shared floating-point types and constants for the sensor-math FPU sharing logic.
package fpu_pkg;

  localparam int FP_W = 32;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_ADD = 1'b1
  } fpOp_e;

  // Single-precision filter coefficients used by the complementary filter and gyro integration.
  localparam logic [FP_W-1:0] K_0P1  = 32'h3DCCC800;
  localparam logic [FP_W-1:0] K_GYDT = 32'h3D385000;
  localparam logic [FP_W-1:0] K_0P9  = 32'h3F666600;

endpackage

// File: rtl/fpu_share_arbiter_if.sv
// Requester and core-side signals of the FPU share arbiter; the arbiter uses the
// slave modport, the requesters plus the MULT/ADD cores sit on the master side.
interface fpu_share_arbiter_if
  import fpu_pkg::*;
#(
  parameter int NREQ = 3
) ();

  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      op;
  logic [FP_W*NREQ-1:0] a_flat;
  logic [FP_W*NREQ-1:0] b_flat;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      done;
  logic [FP_W*NREQ-1:0] result_flat;
  logic [NREQ-1:0]      pending;
  logic [FP_W-1:0]      mul_a;
  logic [FP_W-1:0]      mul_b;
  logic [FP_W-1:0]      mul_res;
  logic [FP_W-1:0]      add_a;
  logic [FP_W-1:0]      add_b;
  logic [FP_W-1:0]      add_res;
  logic                 busy;

  modport slave (
    input  req, op, a_flat, b_flat, mul_res, add_res,
    output ack, done, result_flat, pending, mul_a, mul_b, add_a, add_b, busy
  );

  modport master (
    output req, op, a_flat, b_flat, mul_res, add_res,
    input  ack, done, result_flat, pending, mul_a, mul_b, add_a, add_b, busy
  );

endinterface

// File: rtl/fpu_share_arbiter_tag_pipe.sv
// Fixed-depth shift register that carries a {valid, id} tag alongside an FP core,
// so the tag emerges exactly when the core result for that operation is valid.
module fpu_tag_pipe #(
  parameter int LAT = 5,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] tag_i,
  output logic [W-1:0] tag_o
);

  logic [W-1:0] stage_q [LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LAT; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int k = 1; k < LAT; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign tag_o = stage_q[LAT-1];

endmodule

// File: rtl/fpu_share_arbiter.sv
// Round-robin sharing of one MULT and one ADD core among NREQ requesters; each
// requester gets an ack on issue and a done pulse with a registered result.
module fpu_share_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int MUL_LAT = 5,
  parameter int ADD_LAT = 7
) (
  input  logic               clk,
  input  logic               rst,
  fpu_share_arbiter_if.slave fpuBus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]       rrPtr_q,   rrPtr_d;
  logic [NREQ-1:0]      pending_q, pending_d;
  logic [NREQ-1:0]      ack_q,     ack_d;
  logic [NREQ-1:0]      done_q,    done_d;
  logic [FP_W*NREQ-1:0] result_q,  result_d;
  logic [FP_W-1:0]      mulA_q,    mulA_d;
  logic [FP_W-1:0]      mulB_q,    mulB_d;
  logic [FP_W-1:0]      addA_q,    addA_d;
  logic [FP_W-1:0]      addB_q,    addB_d;

  logic [NREQ-1:0] eligible;
  logic [IDW:0]    scanIdx;
  logic            grantValid;
  logic [IDW-1:0]  grantId;
  logic            grantOp;
  tag_t            mulTagIn, mulTagOut;
  tag_t            addTagIn, addTagOut;

  // A requester with an op in flight is skipped until its completion edge has passed.
  always_comb begin
    eligible   = fpuBus.req & ~pending_q;
    grantValid = 1'b0;
    grantId    = '0;
    scanIdx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scanIdx = {1'b0, rrPtr_q} + (IDW+1)'(k);
      if (scanIdx >= (IDW+1)'(NREQ)) begin
        scanIdx = scanIdx - (IDW+1)'(NREQ);
      end
      if (!grantValid && eligible[scanIdx[IDW-1:0]]) begin
        grantValid = 1'b1;
        grantId    = scanIdx[IDW-1:0];
      end
    end
    grantOp = fpuBus.op[grantId];
  end

  always_comb begin
    mulTagIn.valid = grantValid && (grantOp == OP_MUL);
    mulTagIn.id    = grantId;
    addTagIn.valid = grantValid && (grantOp == OP_ADD);
    addTagIn.id    = grantId;
  end

  fpu_tag_pipe #(
    .LAT (MUL_LAT),
    .W   (IDW + 1)
  ) mulTagPipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (mulTagIn),
    .tag_o (mulTagOut)
  );

  fpu_tag_pipe #(
    .LAT (ADD_LAT),
    .W   (IDW + 1)
  ) addTagPipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (addTagIn),
    .tag_o (addTagOut)
  );

  // Completions and the new grant never share an id, so their updates cannot collide.
  always_comb begin
    pending_d = pending_q;
    ack_d     = '0;
    done_d    = '0;
    result_d  = result_q;
    rrPtr_d   = rrPtr_q;
    mulA_d    = mulA_q;
    mulB_d    = mulB_q;
    addA_d    = addA_q;
    addB_d    = addB_q;

    if (mulTagOut.valid) begin
      result_d[int'(mulTagOut.id)*FP_W +: FP_W] = fpuBus.mul_res;
      pending_d[mulTagOut.id] = 1'b0;
      done_d[mulTagOut.id]    = 1'b1;
    end

    if (addTagOut.valid) begin
      result_d[int'(addTagOut.id)*FP_W +: FP_W] = fpuBus.add_res;
      pending_d[addTagOut.id] = 1'b0;
      done_d[addTagOut.id]    = 1'b1;
    end

    if (grantValid) begin
      pending_d[grantId] = 1'b1;
      ack_d[grantId]     = 1'b1;
      rrPtr_d = (int'(grantId) == NREQ - 1) ? '0 : grantId + 1'b1;
      if (grantOp == OP_MUL) begin
        mulA_d = fpuBus.a_flat[int'(grantId)*FP_W +: FP_W];
        mulB_d = fpuBus.b_flat[int'(grantId)*FP_W +: FP_W];
      end else begin
        addA_d = fpuBus.a_flat[int'(grantId)*FP_W +: FP_W];
        addB_d = fpuBus.b_flat[int'(grantId)*FP_W +: FP_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rrPtr_q   <= '0;
      pending_q <= '0;
      ack_q     <= '0;
      done_q    <= '0;
      result_q  <= '0;
      mulA_q    <= '0;
      mulB_q    <= '0;
      addA_q    <= '0;
      addB_q    <= '0;
    end else begin
      rrPtr_q   <= rrPtr_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      result_q  <= result_d;
      mulA_q    <= mulA_d;
      mulB_q    <= mulB_d;
      addA_q    <= addA_d;
      addB_q    <= addB_d;
    end
  end

  assign fpuBus.ack         = ack_q;
  assign fpuBus.done        = done_q;
  assign fpuBus.result_flat = result_q;
  assign fpuBus.pending     = pending_q;
  assign fpuBus.mul_a       = mulA_q;
  assign fpuBus.mul_b       = mulB_q;
  assign fpuBus.add_a       = addA_q;
  assign fpuBus.add_b       = addB_q;
  assign fpuBus.busy        = |pending_q;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Scoreboard bench for fpu_share_arbiter: a cycle-stamped reference model predicts
// ack/done events, behavioural MULT/ADD pipelines stand in for the cores.
module tb_fpu_share_arbiter;
  import fpu_pkg::*;

  localparam int NREQ    = 3;
  localparam int MUL_LAT = 5;
  localparam int ADD_LAT = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  fpu_share_arbiter_if #(.NREQ(NREQ)) fpuBus ();

  fpu_share_arbiter #(
    .NREQ    (NREQ),
    .MUL_LAT (MUL_LAT),
    .ADD_LAT (ADD_LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .fpuBus (fpuBus)
  );

  always #5 clk = ~clk;

  // Stand-in core arithmetic: exact IEEE results for the directed operand pairs,
  // otherwise an arbitrary but deterministic mixing of the operands.
  function automatic logic [31:0] coreMul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    return (a * b) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] coreAdd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a + {b[15:0], b[31:16]};
  endfunction

  // Result appears LAT clocks after the operand registers load, counting that load edge.
  logic [31:0] mulPipe [MUL_LAT-1];
  logic [31:0] addPipe [ADD_LAT-1];

  always @(posedge clk) begin
    mulPipe[0] <= coreMul(fpuBus.mul_a, fpuBus.mul_b);
    for (int k = 1; k < MUL_LAT - 1; k++) mulPipe[k] <= mulPipe[k-1];
    addPipe[0] <= coreAdd(fpuBus.add_a, fpuBus.add_b);
    for (int k = 1; k < ADD_LAT - 1; k++) addPipe[k] <= addPipe[k-1];
  end

  assign fpuBus.mul_res = mulPipe[MUL_LAT-2];
  assign fpuBus.add_res = addPipe[ADD_LAT-2];

  typedef struct {
    bit          isDone;
    int          id;
    int          at;
    logic [31:0] data;
  } expect_t;

  typedef struct {
    int id;
    int at;
  } flight_t;

  expect_t         expQ[$];
  flight_t         flights[$];
  logic [NREQ-1:0] pendModel = '0;
  int              ptrModel  = 0;
  int              mW;
  int              mLat;
  logic [31:0]     mRes;

  // Reference model: evaluated at the edge closing cycle cyc, pushes stamped expectations.
  always @(posedge clk) begin
    if (!rst) begin
      expQ.delete();
      flights.delete();
      pendModel = '0;
      ptrModel  = 0;
    end else begin
      mW = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (mW < 0 && fpuBus.req[(ptrModel + k) % NREQ] && !pendModel[(ptrModel + k) % NREQ])
          mW = (ptrModel + k) % NREQ;
      end
      for (int j = flights.size() - 1; j >= 0; j--) begin
        if (flights[j].at == cyc + 1) begin
          pendModel[flights[j].id] = 1'b0;
          flights.delete(j);
        end
      end
      if (mW >= 0) begin
        if (fpuBus.op[mW]) begin
          mLat = ADD_LAT;
          mRes = coreAdd(fpuBus.a_flat[mW*32 +: 32], fpuBus.b_flat[mW*32 +: 32]);
        end else begin
          mLat = MUL_LAT;
          mRes = coreMul(fpuBus.a_flat[mW*32 +: 32], fpuBus.b_flat[mW*32 +: 32]);
        end
        expQ.push_back('{isDone: 1'b0, id: mW, at: cyc + 1, data: 32'h0});
        expQ.push_back('{isDone: 1'b1, id: mW, at: cyc + 1 + mLat, data: mRes});
        flights.push_back('{id: mW, at: cyc + 1 + mLat});
        pendModel[mW] = 1'b1;
        ptrModel      = (mW + 1) % NREQ;
      end
    end
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] slotOf(input int i);
    return fpuBus.result_flat[i*32 +: 32];
  endfunction

  logic [NREQ-1:0] expAck;
  logic [NREQ-1:0] expDone;
  logic [31:0]     expRes [NREQ];

  // Monitor: consumes every expectation stamped for the current cycle and compares.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("rstAck",     fpuBus.ack,     '0);
      checkOutput("rstDone",    fpuBus.done,    '0);
      checkOutput("rstPending", fpuBus.pending, '0);
      checkOutput("rstResult",  (fpuBus.result_flat == '0), 1);
    end else begin
      expAck  = '0;
      expDone = '0;
      for (int j = expQ.size() - 1; j >= 0; j--) begin
        if (expQ[j].at == cyc) begin
          if (expQ[j].isDone) begin
            expDone[expQ[j].id] = 1'b1;
            expRes[expQ[j].id]  = expQ[j].data;
          end else begin
            expAck[expQ[j].id] = 1'b1;
          end
          expQ.delete(j);
        end
      end
      checkOutput("ack",  fpuBus.ack,  expAck);
      checkOutput("done", fpuBus.done, expDone);
      for (int i = 0; i < NREQ; i++) begin
        if (expDone[i]) checkOutput($sformatf("result%0d", i), slotOf(i), expRes[i]);
      end
      checkOutput("pending", fpuBus.pending, pendModel);
      checkOutput("busy",    fpuBus.busy,    |pendModel);
    end
  end

  task automatic applyStimulus(input int id, input logic opv, input logic [31:0] a, input logic [31:0] b);
    fpuBus.op[id]             = opv;
    fpuBus.a_flat[id*32 +: 32] = a;
    fpuBus.b_flat[id*32 +: 32] = b;
    fpuBus.req[id]            = 1'b1;
  endtask

  task automatic waitPulse(input int id, input bit isDone, input string name, output int at);
    at = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (isDone ? fpuBus.done[id] : fpuBus.ack[id]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) timeoutFail(name);
  endtask

  task automatic resetDut();
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic randomPhase(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (fpuBus.ack[i]) begin
          fpuBus.op[i]              = 1'($urandom_range(1, 0));
          fpuBus.a_flat[i*32 +: 32] = $urandom();
          fpuBus.b_flat[i*32 +: 32] = $urandom();
          if ($urandom_range(1, 0) == 0) fpuBus.req[i] = 1'b0;
        end else if (!fpuBus.req[i] && $urandom_range(3, 0) == 0) begin
          applyStimulus(i, 1'($urandom_range(1, 0)), $urandom(), $urandom());
        end
      end
    end
  endtask

  int          ackAt, doneAt, ack0At, done0At;
  int          ackOrder[$];
  int          ackCycles[$];
  int          lastDone, heldAcks, strayDone;
  logic [31:0] aMul, bMul, aAdd, bAdd;

  initial begin
    fpuBus.req    = '0;
    fpuBus.op     = '0;
    fpuBus.a_flat = '0;
    fpuBus.b_flat = '0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Single multiply: 2.0 * 3.0 on requester 0.
    @(negedge clk);
    applyStimulus(0, OP_MUL, 32'h40000000, 32'h40400000);
    waitPulse(0, 1'b0, "mulAck", ackAt);
    fpuBus.req[0] = 1'b0;
    waitPulse(0, 1'b1, "mulDone", doneAt);
    checkOutput("mulLatency", doneAt - ackAt, MUL_LAT);
    checkOutput("mulSlot0", slotOf(0), 32'h40C00000);
    @(negedge clk);
    checkOutput("mulPendClear", fpuBus.pending[0], 1'b0);

    // Single add: 1.0 + 2.0 on requester 1.
    applyStimulus(1, OP_ADD, 32'h3F800000, 32'h40000000);
    waitPulse(1, 1'b0, "addAck", ackAt);
    fpuBus.req[1] = 1'b0;
    waitPulse(1, 1'b1, "addDone", doneAt);
    checkOutput("addLatency", doneAt - ackAt, ADD_LAT);
    checkOutput("addSlot1", slotOf(1), 32'h40400000);

    // Round-robin from a fresh reset with every requester raised together.
    resetDut();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, OP_MUL, $urandom(), $urandom());
    ackOrder.delete();
    ackCycles.delete();
    for (int t = 0; t < 10 && ackOrder.size() < NREQ; t++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (fpuBus.ack[i]) begin
          ackOrder.push_back(i);
          ackCycles.push_back(cyc);
          fpuBus.req[i] = 1'b0;
        end
      end
    end
    if (ackOrder.size() == NREQ) begin
      for (int k = 0; k < NREQ; k++) checkOutput($sformatf("rrOrder%0d", k), ackOrder[k], k);
      checkOutput("rrBackToBack", ackCycles[NREQ-1] - ackCycles[0], NREQ - 1);
    end else begin
      timeoutFail("rrAcks");
    end
    repeat (12) @(negedge clk);

    // Concurrent completion: add issued two cycles before a multiply.
    aAdd = $urandom();
    bAdd = $urandom();
    aMul = $urandom();
    bMul = $urandom();
    applyStimulus(1, OP_ADD, aAdd, bAdd);
    waitPulse(1, 1'b0, "concAddAck", ackAt);
    fpuBus.req[1] = 1'b0;
    @(negedge clk);
    applyStimulus(0, OP_MUL, aMul, bMul);
    waitPulse(0, 1'b0, "concMulAck", ack0At);
    fpuBus.req[0] = 1'b0;
    checkOutput("concAckGap", ack0At - ackAt, 2);
    waitPulse(0, 1'b1, "concMulDone", done0At);
    checkOutput("concDone1", fpuBus.done[1], 1'b1);
    checkOutput("concSlot0", slotOf(0), coreMul(aMul, bMul));
    checkOutput("concSlot1", slotOf(1), coreAdd(aAdd, bAdd));
    repeat (4) @(negedge clk);

    // Held request: a re-grant may only follow each completion.
    applyStimulus(2, OP_MUL, $urandom(), $urandom());
    lastDone = -1;
    heldAcks = 0;
    for (int t = 0; t < 26; t++) begin
      @(negedge clk);
      if (fpuBus.ack[2]) begin
        heldAcks++;
        if (lastDone >= 0) checkOutput("heldReAckGap", cyc - lastDone, 1);
        fpuBus.a_flat[64 +: 32] = $urandom();
        fpuBus.b_flat[64 +: 32] = $urandom();
      end
      if (fpuBus.done[2]) lastDone = cyc;
    end
    fpuBus.req[2] = 1'b0;
    checkOutput("heldAckCount", heldAcks, 5);
    repeat (12) @(negedge clk);

    // Reset two cycles after an accepted multiply.
    applyStimulus(0, OP_MUL, $urandom(), $urandom());
    waitPulse(0, 1'b0, "midAck", ackAt);
    fpuBus.req[0] = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("midRstAck",     fpuBus.ack,     '0);
    checkOutput("midRstDone",    fpuBus.done,    '0);
    checkOutput("midRstPending", fpuBus.pending, '0);
    checkOutput("midRstBusy",    fpuBus.busy,    1'b0);
    checkOutput("midRstResult",  (fpuBus.result_flat == '0), 1);
    checkOutput("midRstMulA",    fpuBus.mul_a,   '0);
    checkOutput("midRstMulB",    fpuBus.mul_b,   '0);
    checkOutput("midRstAddA",    fpuBus.add_a,   '0);
    checkOutput("midRstAddB",    fpuBus.add_b,   '0);
    @(negedge clk);
    rst = 1'b1;
    strayDone = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (|fpuBus.done) strayDone++;
    end
    checkOutput("noStrayDone", strayDone, 0);
    aMul = $urandom();
    bMul = $urandom();
    applyStimulus(0, OP_MUL, aMul, bMul);
    waitPulse(0, 1'b0, "postRstAck", ackAt);
    fpuBus.req[0] = 1'b0;
    waitPulse(0, 1'b1, "postRstDone", doneAt);
    checkOutput("postRstLatency", doneAt - ackAt, MUL_LAT);
    checkOutput("postRstSlot0", slotOf(0), coreMul(aMul, bMul));

    // Random traffic, then drain.
    randomPhase(400);
    fpuBus.req = '0;
    repeat (20) @(negedge clk);
    checkOutput("drainQueue", expQ.size(), 0);
    checkOutput("drainBusy",  fpuBus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
